// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Branch opcode encodings and the relative-target helper shared by
//            the program-counter sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam logic [2:0] BR_SEQ  = 3'b000;
    localparam logic [2:0] BR_CBZ  = 3'b001;
    localparam logic [2:0] BR_CBNZ = 3'b010;
    localparam logic [2:0] BR_B    = 3'b011;
    localparam logic [2:0] BR_BL   = 3'b100;
    localparam logic [2:0] BR_BR   = 3'b101;
    localparam logic [2:0] BR_RET  = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    // Widest supported PC; narrower callers zero-extend and keep the low bits,
    // which is exact because the sum is taken modulo 2^XLEN.
    localparam int C_MAX_XLEN = 64;

    function automatic logic [C_MAX_XLEN-1:0] rel_target(
        input logic [C_MAX_XLEN-1:0] pc,
        input logic [C_MAX_XLEN-1:0] imm,
        input int                    shamt
    );
        return pc + (imm << shamt);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ret_addr_stack.sv
`default_nettype none
// ============================================================================
// Module   : ret_addr_stack
// Purpose  : Circular return-address stack; a push when full overwrites the
//            oldest entry, a pop when empty is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module ret_addr_stack #(
    parameter int XLEN      = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;     // next slot to write; top lives one below
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_top_idx;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_mem[r_ptr] <= din;
            r_ptr        <= r_ptr + C_PTR_ONE;
            if (r_count != C_DEPTH) begin
                r_count <= r_count + C_CNT_ONE;
            end
        end else if (pop && (r_count != '0)) begin
            r_ptr   <= r_ptr - C_PTR_ONE;
            r_count <= r_count - C_CNT_ONE;
        end
    end

    assign w_top_idx = r_ptr - C_PTR_ONE;
    assign top       = r_mem[w_top_idx];
    assign empty     = (r_count == '0);
    assign full      = (r_count == C_DEPTH);

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Registered program counter with branch decode, return-address
//            stack, stall and sticky misaligned-target fault (XLEN <= 64).
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4,
    parameter int              IMM_SHIFT = 2
) (
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic            Stall,
    input  logic [2:0]      BrOp,
    input  logic            ALUZero,
    input  logic [XLEN-1:0] SignExtImm,
    input  logic [XLEN-1:0] RegTarget,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] NextPC,
    output logic [XLEN-1:0] LinkAddr,
    output logic            Taken,
    output logic            RasEmpty,
    output logic            Fault
);

    logic [XLEN-1:0]       r_pc;
    logic                  r_fault;
    logic [C_MAX_XLEN-1:0] w_rel_wide;
    logic [XLEN-1:0]       w_rel;
    logic [XLEN-1:0]       w_target;
    logic                  w_redirect;
    logic                  w_misalign;
    logic                  w_advance;
    logic                  w_push;
    logic                  w_pop;
    logic [XLEN-1:0]       w_ras_top;
    logic                  w_ras_empty;
    logic                  w_unused_ras_full;

    assign w_rel_wide = rel_target(C_MAX_XLEN'(r_pc), C_MAX_XLEN'(SignExtImm), IMM_SHIFT);
    assign w_rel      = w_rel_wide[XLEN-1:0];
    assign LinkAddr   = r_pc + XLEN'(4);

    always_comb begin
        w_redirect = 1'b0;
        w_target   = LinkAddr;
        case (BrOp)
            BR_CBZ: begin
                w_redirect = ALUZero;
                w_target   = w_rel;
            end
            BR_CBNZ: begin
                w_redirect = !ALUZero;
                w_target   = w_rel;
            end
            BR_B, BR_BL: begin
                w_redirect = 1'b1;
                w_target   = w_rel;
            end
            BR_BR: begin
                w_redirect = 1'b1;
                w_target   = RegTarget;
            end
            BR_RET: begin
                w_redirect = 1'b1;
                w_target   = w_ras_empty ? RegTarget : w_ras_top;
            end
            default: begin
                w_redirect = 1'b0;
                w_target   = LinkAddr;
            end
        endcase
    end

    // A faulted sequencer is inert: no redirect, and the PC is re-presented.
    assign Taken      = w_redirect && !r_fault;
    assign w_misalign = Taken && (w_target[1:0] != 2'b00);
    assign NextPC     = (r_fault || w_misalign) ? r_pc :
                        (Taken ? w_target : LinkAddr);

    assign w_advance = !Stall && !r_fault && !w_misalign;
    assign w_push    = w_advance && (BrOp == BR_BL);
    assign w_pop     = w_advance && (BrOp == BR_RET);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            if (w_advance) begin
                r_pc <= NextPC;
            end
            if (!Stall && w_misalign) begin
                r_fault <= 1'b1;
            end
        end
    end

    ret_addr_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (LinkAddr),
        .top     (w_ras_top),
        .empty   (w_ras_empty),
        .full    (w_unused_ras_full)
    );

    assign PC       = r_pc;
    assign RasEmpty = w_ras_empty;
    assign Fault    = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed, table-driven checks of pc_sequencer (RESET_PC=0x100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_CBZ  = 3'b001;
    localparam logic [2:0] OP_CBNZ = 3'b010;
    localparam logic [2:0] OP_B    = 3'b011;
    localparam logic [2:0] OP_BL   = 3'b100;
    localparam logic [2:0] OP_BR   = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;
    localparam logic [63:0] M4     = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef struct {
        logic [2:0]  op;
        logic        zero;
        logic [63:0] imm;
        logic [63:0] regt;
        logic        stall;
        logic [63:0] exp_next;
        logic        exp_taken;
        logic [63:0] exp_pc;
        logic        exp_empty;
        logic        exp_fault;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [2:0]  br_op;
    logic        alu_zero;
    logic [63:0] imm;
    logic [63:0] regt;
    logic [63:0] pc;
    logic [63:0] next_pc;
    logic [63:0] link;
    logic        taken;
    logic        ras_empty;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    pc_sequencer #(
        .XLEN      (64),
        .RESET_PC  (64'h100),
        .RAS_DEPTH (4),
        .IMM_SHIFT (2)
    ) dut (
        .CLK        (clk),
        .Reset_n    (rst_n),
        .Stall      (stall),
        .BrOp       (br_op),
        .ALUZero    (alu_zero),
        .SignExtImm (imm),
        .RegTarget  (regt),
        .PC         (pc),
        .NextPC     (next_pc),
        .LinkAddr   (link),
        .Taken      (taken),
        .RasEmpty   (ras_empty),
        .Fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic zero, input logic [63:0] i,
                       input logic [63:0] r, input logic st, input logic [63:0] enext,
                       input logic etaken, input logic [63:0] epc, input logic eempty,
                       input logic efault);
        vec_t v;
        v.op = op; v.zero = zero; v.imm = i; v.regt = r; v.stall = st;
        v.exp_next = enext; v.exp_taken = etaken; v.exp_pc = epc;
        v.exp_empty = eempty; v.exp_fault = efault;
        vecs.push_back(v);
    endtask

    initial begin
        //  op       z  imm      regt      st  next      tk pc        emp flt
        add(OP_SEQ,  0, 64'h0,   64'h0,    0,  64'h104,  0, 64'h104,  1,  0);
        add(OP_SEQ,  0, 64'h0,   64'h0,    0,  64'h108,  0, 64'h108,  1,  0);
        add(OP_SEQ,  0, 64'h0,   64'h0,    0,  64'h10C,  0, 64'h10C,  1,  0);
        add(OP_BR,   0, 64'h0,   64'h40,   0,  64'h40,   1, 64'h40,   1,  0);
        add(OP_CBZ,  1, M4,      64'h0,    0,  64'h30,   1, 64'h30,   1,  0);
        add(OP_BR,   0, 64'h0,   64'h40,   0,  64'h40,   1, 64'h40,   1,  0);
        add(OP_CBZ,  0, M4,      64'h0,    0,  64'h44,   0, 64'h44,   1,  0);
        add(OP_BR,   0, 64'h0,   64'h40,   0,  64'h40,   1, 64'h40,   1,  0);
        add(OP_CBNZ, 0, M4,      64'h0,    0,  64'h30,   1, 64'h30,   1,  0);
        add(OP_BR,   0, 64'h0,   64'h40,   0,  64'h40,   1, 64'h40,   1,  0);
        add(OP_CBNZ, 1, M4,      64'h0,    0,  64'h44,   0, 64'h44,   1,  0);
        add(OP_BR,   0, 64'h0,   64'h200,  0,  64'h200,  1, 64'h200,  1,  0);
        add(OP_BL,   0, 64'h10,  64'h0,    0,  64'h240,  1, 64'h240,  0,  0);
        add(OP_RET,  0, 64'h0,   64'h999,  0,  64'h204,  1, 64'h204,  1,  0);
        add(OP_RSVD, 0, 64'h80,  64'h0,    0,  64'h208,  0, 64'h208,  1,  0);
        // BL held by stall for three cycles, then completes once
        add(OP_BL,   0, 64'h4,   64'h0,    1,  64'h218,  1, 64'h208,  1,  0);
        add(OP_BL,   0, 64'h4,   64'h0,    1,  64'h218,  1, 64'h208,  1,  0);
        add(OP_BL,   0, 64'h4,   64'h0,    1,  64'h218,  1, 64'h208,  1,  0);
        add(OP_BL,   0, 64'h4,   64'h0,    0,  64'h218,  1, 64'h218,  0,  0);
        add(OP_RET,  0, 64'h0,   64'h0,    0,  64'h20C,  1, 64'h20C,  1,  0);
        // five nested calls overflow a depth-4 stack
        add(OP_BL,   0, 64'h40,  64'h0,    0,  64'h30C,  1, 64'h30C,  0,  0);
        add(OP_BL,   0, 64'h40,  64'h0,    0,  64'h40C,  1, 64'h40C,  0,  0);
        add(OP_BL,   0, 64'h40,  64'h0,    0,  64'h50C,  1, 64'h50C,  0,  0);
        add(OP_BL,   0, 64'h40,  64'h0,    0,  64'h60C,  1, 64'h60C,  0,  0);
        add(OP_BL,   0, 64'h40,  64'h0,    0,  64'h70C,  1, 64'h70C,  0,  0);
        add(OP_RET,  0, 64'h0,   64'h800,  0,  64'h610,  1, 64'h610,  0,  0);
        add(OP_RET,  0, 64'h0,   64'h800,  0,  64'h510,  1, 64'h510,  0,  0);
        add(OP_RET,  0, 64'h0,   64'h800,  0,  64'h410,  1, 64'h410,  0,  0);
        add(OP_RET,  0, 64'h0,   64'h800,  0,  64'h310,  1, 64'h310,  1,  0);
        add(OP_RET,  0, 64'h0,   64'h800,  0,  64'h800,  1, 64'h800,  1,  0);
        // wrap-around at the top of the address space
        add(OP_BR,   0, 64'h0,   M4,       0,  M4,       1, M4,       1,  0);
        add(OP_B,    0, 64'h2,   64'h0,    0,  64'h4,    1, 64'h4,    1,  0);
        // misaligned target: no fault while stalled, sticky fault otherwise
        add(OP_BR,   0, 64'h0,   64'h1002, 1,  64'h4,    1, 64'h4,    1,  0);
        add(OP_BR,   0, 64'h0,   64'h1002, 0,  64'h4,    1, 64'h4,    1,  1);
        add(OP_B,    0, 64'h4,   64'h0,    0,  64'h4,    0, 64'h4,    1,  1);
        add(OP_RET,  0, 64'h0,   64'h800,  0,  64'h4,    0, 64'h4,    1,  1);

        rst_n = 1'b0; stall = 1'b0; br_op = OP_SEQ; alu_zero = 1'b0;
        imm = '0; regt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc",    pc,        64'h100);
        chk("reset_link",  link,      64'h104);
        chk("reset_empty", {63'd0, ras_empty}, 64'd1);
        chk("reset_fault", {63'd0, fault},     64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            br_op = vecs[i].op; alu_zero = vecs[i].zero; imm = vecs[i].imm;
            regt = vecs[i].regt; stall = vecs[i].stall;
            #2;
            chk($sformatf("v%0d_next", i),  next_pc, vecs[i].exp_next);
            chk($sformatf("v%0d_taken", i), {63'd0, taken}, {63'd0, vecs[i].exp_taken});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i),    pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_empty", i), {63'd0, ras_empty}, {63'd0, vecs[i].exp_empty});
            chk($sformatf("v%0d_fault", i), {63'd0, fault}, {63'd0, vecs[i].exp_fault});
        end

        // asynchronous reset while faulted, away from any clock edge
        br_op = OP_SEQ; stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midfault_rst_pc",    pc,   64'h100);
        chk("midfault_rst_fault", {63'd0, fault}, 64'd0);
        chk("midfault_rst_link",  link, 64'h104);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_seq_pc", pc, 64'h104);

        // push, then reset while stalled: stack must come back empty
        br_op = OP_BL; imm = 64'h40;
        @(posedge clk);
        #1;
        chk("pre_stall_bl_pc",    pc, 64'h204);
        chk("pre_stall_bl_empty", {63'd0, ras_empty}, 64'd0);
        stall = 1'b1; br_op = OP_RET; regt = 64'h500;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midstall_rst_pc",    pc, 64'h100);
        chk("midstall_rst_empty", {63'd0, ras_empty}, 64'd1);
        chk("midstall_rst_ret",   next_pc, 64'h500);
        @(posedge clk);
        #1 rst_n = 1'b1; stall = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ret_pc", pc, 64'h500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter unit for the single-cycle ARMv8-subset CPU. It is the next generation of the combinational next-PC logic. It holds the PC in a register and decodes a 3-bit branch opcode covering CBZ, CBNZ, B, BL, BR and RET. It keeps an internal return-address stack (RAS) for BL/RET, supports stall, and detects misaligned targets. It sits between the control unit / sign-extender / ALU and the instruction memory address port.

## Interface
Parameters:
- XLEN, 64, datapath and PC width (≥8)
- RESET_PC, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2)
- IMM_SHIFT, 2, left shift applied to SignExtImm (word offsets)

Ports:
- CLK  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Stall  in  1  hold PC and RAS this cycle
- BrOp  in  3  branch opcode (see Operation)
- ALUZero  in  1  zero flag from ALU
- SignExtImm  in  XLEN  sign-extended branch offset, in words
- RegTarget  in  XLEN  register operand for BR, and fallback for RET
- PC  out  XLEN  current PC (registered)
- NextPC  out  XLEN  combinational PC to be loaded at next edge
- LinkAddr  out  XLEN  PC+4 (combinational, written to X30 by BL)
- Taken  out  1  combinational: current instruction redirects
- RasEmpty  out  1  combinational: RAS count == 0
- Fault  out  1  registered, sticky misaligned-target flag

## Operation
- BrOp encodings:
  - 000 SEQ
  - 001 CBZ (taken iff ALUZero)
  - 010 CBNZ (taken iff !ALUZero)
  - 011 B
  - 100 BL
  - 101 BR
  - 110 RET
  - 111 reserved: behaves as SEQ.
- Targets:
  - Relative (CBZ/CBNZ/B/BL) = PC + (SignExtImm << IMM_SHIFT).
  - BR = RegTarget.
  - RET = RAS top if !RasEmpty, else RegTarget.
- NextPC = target when Taken, else PC+4. All arithmetic is modulo 2^XLEN; wrap-around is silent.
- Misaligned: if Taken and target[1:0] != 0, then NextPC = PC, PC is not updated, and Fault is set at the edge.
- While Fault = 1:
  - PC and RAS are frozen.
  - NextPC = PC and Taken = 0.
  - Only reset clears Fault.
- RAS is a circular buffer with top pointer and count (0..RAS_DEPTH):
  - BL pushes LinkAddr. When full, the oldest entry is overwritten and count stays at RAS_DEPTH.
  - RET pops when non-empty (count−1). RET on an empty RAS does not pop and uses RegTarget.
  - Push/pop occur only on an edge where PC updates (no Stall, no Fault, no misalignment).
- Stall = 1: PC, RAS and Fault hold. NextPC/Taken are still computed for observation, and no misalignment Fault is latched.

## Timing
- Reset (Reset_n low, asynchronous): PC=RESET_PC, RAS count=0, pointer=0, Fault=0. Derived outputs follow: LinkAddr=RESET_PC+4, RasEmpty=1.
- Release of reset is synchronous: the first update occurs at the first rising CLK edge after Reset_n is sampled high.
- Latency:
  - PC ← NextPC at each rising edge (1 cycle).
  - NextPC, Taken, LinkAddr and RasEmpty are combinational from current PC and inputs, with no registered delay.
- A BL followed immediately by a RET in the next cycle returns to the BL's PC+4, because the push is visible to the next cycle.
- Reset asserted mid-stall or mid-fault overrides everything immediately.

## Structure
- Package pc_pkg:
  - BrOp localparams (BR_SEQ … BR_RSVD).
  - A function computing relative targets.
- Sub-module ret_addr_stack, parameterised XLEN and RAS_DEPTH:
  - Inputs: push, pop, din.
  - Outputs: top, empty, full.
  - Async active-low reset on CLK/Reset_n.
- pc_sequencer holds the PC/Fault registers and the next-PC mux.

## Test plan
- Reset with RESET_PC=0x100: PC=0x100, LinkAddr=0x104, RasEmpty=1, Fault=0; three SEQ cycles give PC=0x10C.
- CBZ at PC=0x40, imm=−4, ALUZero=1: NextPC=0x30 and PC=0x30 next cycle. Same with ALUZero=0 → 0x44. CBNZ gives the inverse.
- BL at 0x200, imm=0x10 → PC=0x240; RET next cycle → PC=0x204 and RasEmpty=1.
- Five nested BLs with RAS_DEPTH=4 and five RETs:
  - The first four RETs return in LIFO order.
  - The fifth RET (empty RAS) jumps to RegTarget=0x800.
- BR with RegTarget=0x1002: Fault=1 after the edge, PC holds at its prior value, and further branches are ignored until reset.
- Stall held 3 cycles during BL: PC and RAS are unchanged; on release, BL completes once. B at PC=2^XLEN−4 with imm=2 wraps to 0x4.
